// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM/WB pipeline register with load extraction, misalign flag and retire counter
module mem_wb_stage #(
    parameter int RETIRE_W = 32,
    parameter bit EN_TRACE = 0
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                Stall,
    input  logic                Flush,
    input  logic                Valid_M,
    input  logic [31:0]         pc_M,
    input  logic [31:0]         IR_M,
    input  logic [31:0]         MemAddr_M,
    input  logic [31:0]         DataOut_M,
    input  logic [31:0]         AluOut_M,
    input  logic                MemToReg_M,
    input  logic                RegWrEn_M,
    input  logic [4:0]          RegDst_M,
    output logic                Valid_W,
    output logic [31:0]         pc_W,
    output logic [31:0]         IR_W,
    output logic [31:0]         WbData_W,
    output logic [4:0]          RegDst_W,
    output logic                RegWrEn_W,
    output logic                LoadMisalign_W,
    output logic [RETIRE_W-1:0] RetireCnt
);

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;

    logic [5:0]  opCode;
    logic [1:0]  byteOff;
    logic [7:0]  byteVal;
    logic [15:0] halfVal;
    logic [31:0] loadData;
    logic [31:0] wbData;
    logic        isHalf;
    logic        isWord;
    logic        misalign;
    logic        wrEn;
    logic        retire;

    assign opCode  = IR_M[31:26];
    assign byteOff = MemAddr_M[1:0];

    always_comb begin
        byteVal = DataOut_M[7:0];
        case (byteOff)
            2'd0: byteVal = DataOut_M[7:0];
            2'd1: byteVal = DataOut_M[15:8];
            2'd2: byteVal = DataOut_M[23:16];
            2'd3: byteVal = DataOut_M[31:24];
            default: byteVal = DataOut_M[7:0];
        endcase
    end

    assign halfVal = byteOff[1] ? DataOut_M[31:16] : DataOut_M[15:0];

    // Any opcode outside the byte/half loads is handled as a full-word load.
    always_comb begin
        loadData = DataOut_M;
        isHalf   = 1'b0;
        isWord   = 1'b0;
        case (opCode)
            OP_LB:   loadData = {{24{byteVal[7]}}, byteVal};
            OP_LBU:  loadData = {24'h0, byteVal};
            OP_LH: begin
                loadData = {{16{halfVal[15]}}, halfVal};
                isHalf   = 1'b1;
            end
            OP_LHU: begin
                loadData = {16'h0, halfVal};
                isHalf   = 1'b1;
            end
            default: begin
                loadData = DataOut_M;
                isWord   = 1'b1;
            end
        endcase
    end

    assign wbData   = MemToReg_M ? loadData : AluOut_M;
    assign misalign = Valid_M & MemToReg_M &
                      ((isHalf & byteOff[0]) | (isWord & (byteOff != 2'd0)));
    assign wrEn     = Valid_M & RegWrEn_M & (RegDst_M != 5'd0) & ~misalign;
    assign retire   = Valid_M & ~misalign;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            Valid_W        <= 1'b0;
            pc_W           <= 32'h0;
            IR_W           <= 32'h0;
            WbData_W       <= 32'h0;
            RegDst_W       <= 5'd0;
            RegWrEn_W      <= 1'b0;
            LoadMisalign_W <= 1'b0;
            RetireCnt      <= '0;
        end else if (Flush) begin
            Valid_W        <= 1'b0;
            pc_W           <= 32'h0;
            IR_W           <= 32'h0;
            WbData_W       <= 32'h0;
            RegDst_W       <= 5'd0;
            RegWrEn_W      <= 1'b0;
            LoadMisalign_W <= 1'b0;
        end else if (!Stall) begin
            Valid_W        <= Valid_M;
            pc_W           <= pc_M;
            IR_W           <= IR_M;
            WbData_W       <= wbData;
            RegDst_W       <= RegDst_M;
            RegWrEn_W      <= wrEn;
            LoadMisalign_W <= misalign;
            if (retire) begin
                RetireCnt <= RetireCnt + RETIRE_W'(1);
            end
        end
    end

    // Trace reports the values being loaded so it lines up with the edge that commits them.
    generate
        if (EN_TRACE) begin : gTrace
            always @(posedge Clk) begin
                if (Reset && !Flush && !Stall && wrEn) begin
                    $display("%d@%h: $%d <= %h", $time, pc_M, RegDst_M, wbData);
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - scoreboard bench for mem_wb_stage
module tb_mem_wb_stage;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        Stall = 1'b0;
    logic        Flush = 1'b0;
    logic        Valid_M = 1'b0;
    logic [31:0] pc_M = 32'h0;
    logic [31:0] IR_M = 32'h0;
    logic [31:0] MemAddr_M = 32'h0;
    logic [31:0] DataOut_M = 32'h0;
    logic [31:0] AluOut_M = 32'h0;
    logic        MemToReg_M = 1'b0;
    logic        RegWrEn_M = 1'b0;
    logic [4:0]  RegDst_M = 5'd0;
    logic        Valid_W;
    logic [31:0] pc_W;
    logic [31:0] IR_W;
    logic [31:0] WbData_W;
    logic [4:0]  RegDst_W;
    logic        RegWrEn_W;
    logic        LoadMisalign_W;
    logic [3:0]  RetireCnt;

    mem_wb_stage #(.RETIRE_W(4), .EN_TRACE(0)) dut (
        .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush),
        .Valid_M(Valid_M), .pc_M(pc_M), .IR_M(IR_M), .MemAddr_M(MemAddr_M),
        .DataOut_M(DataOut_M), .AluOut_M(AluOut_M), .MemToReg_M(MemToReg_M),
        .RegWrEn_M(RegWrEn_M), .RegDst_M(RegDst_M),
        .Valid_W(Valid_W), .pc_W(pc_W), .IR_W(IR_W), .WbData_W(WbData_W),
        .RegDst_W(RegDst_W), .RegWrEn_W(RegWrEn_W),
        .LoadMisalign_W(LoadMisalign_W), .RetireCnt(RetireCnt)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] wb;
        logic [4:0]  dst;
        logic        we;
        logic        mis;
        logic [3:0]  cnt;
    } exp_t;

    exp_t expQ[$];
    exp_t lastExp;
    int total = 0;
    int bad = 0;
    logic [3:0] expCnt = 4'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: every valid W presentation consumes one expected entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            if (Valid_W === 1'b1) begin
                if (expQ.size() == 0) begin
                    check("unexpected_valid", 32'(Valid_W), 32'h0);
                end else begin
                    e = expQ.pop_front();
                    check("pc_W", pc_W, e.pc);
                    check("WbData_W", WbData_W, e.wb);
                    check("RegDst_W", 32'(RegDst_W), 32'(e.dst));
                    check("RegWrEn_W", 32'(RegWrEn_W), 32'(e.we));
                    check("LoadMisalign_W", 32'(LoadMisalign_W), 32'(e.mis));
                    check("RetireCnt", 32'(RetireCnt), 32'(e.cnt));
                end
            end
        end
    end

    task automatic step(input logic v, input logic [31:0] pc, input logic [5:0] op,
                        input logic [31:0] addr, input logic [31:0] dout, input logic [31:0] alu,
                        input logic mtr, input logic [4:0] dst,
                        input logic [31:0] expWb, input logic expWe, input logic expMis);
        exp_t e;
        Valid_M = v; pc_M = pc; IR_M = {op, 26'h0}; MemAddr_M = addr;
        DataOut_M = dout; AluOut_M = alu; MemToReg_M = mtr; RegWrEn_M = 1'b1; RegDst_M = dst;
        Stall = 1'b0; Flush = 1'b0;
        @(posedge Clk);
        #1;
        if (v) begin
            if (!expMis) expCnt = expCnt + 4'd1;
            e.pc = pc; e.wb = expWb; e.dst = dst; e.we = expWe; e.mis = expMis; e.cnt = expCnt;
            expQ.push_back(e);
            lastExp = e;
        end
    endtask

    task automatic checkIdle(input string tag, input logic [3:0] cnt);
        check({tag, "_Valid_W"}, 32'(Valid_W), 32'h0);
        check({tag, "_RegWrEn_W"}, 32'(RegWrEn_W), 32'h0);
        check({tag, "_LoadMisalign_W"}, 32'(LoadMisalign_W), 32'h0);
        check({tag, "_RetireCnt"}, 32'(RetireCnt), 32'(cnt));
    endtask

    localparam logic [31:0] D = 32'h8899AABB;

    initial begin
        #1;
        checkIdle("reset", 4'd0);
        check("reset_pc_W", pc_W, 32'h0);
        check("reset_WbData_W", WbData_W, 32'h0);
        #20;
        @(negedge Clk);
        Reset = 1'b1;

        step(1, 32'h1000, 6'h20, 32'h100, D, 32'h0, 1, 5'd8, 32'hFFFFFFBB, 1, 0);
        step(1, 32'h1004, 6'h24, 32'h102, D, 32'h0, 1, 5'd8, 32'h00000099, 1, 0);
        step(1, 32'h1008, 6'h21, 32'h102, D, 32'h0, 1, 5'd8, 32'hFFFF8899, 1, 0);
        step(1, 32'h100C, 6'h25, 32'h100, D, 32'h0, 1, 5'd8, 32'h0000AABB, 1, 0);
        step(1, 32'h1010, 6'h23, 32'h100, D, 32'h0, 1, 5'd8, 32'h8899AABB, 1, 0);
        step(1, 32'h1014, 6'h00, 32'h0, D, 32'h12345678, 0, 5'd0, 32'h12345678, 0, 0);
        step(1, 32'h1018, 6'h23, 32'h101, D, 32'h0, 1, 5'd8, 32'h8899AABB, 0, 1);
        step(1, 32'h101C, 6'h25, 32'h103, D, 32'h0, 1, 5'd8, 32'h00008899, 0, 1);
        step(1, 32'h1020, 6'h20, 32'h103, D, 32'h0, 1, 5'd9, 32'hFFFFFF88, 1, 0);
        step(1, 32'h1024, 6'h00, 32'h104, D, 32'h0, 1, 5'd10, 32'h8899AABB, 1, 0);
        step(0, 32'h1028, 6'h23, 32'h100, D, 32'h0, 1, 5'd8, 32'h0, 0, 0);
        checkIdle("bubble", 4'd8);

        step(1, 32'h3000, 6'h23, 32'h200, D, 32'h0, 1, 5'd4, 32'h8899AABB, 1, 0);
        for (int i = 0; i < 3; i++) begin
            Stall = 1'b1; Valid_M = 1'b1; pc_M = 32'h5000 + 32'(i * 4);
            AluOut_M = 32'hDEAD0000 + 32'(i); MemToReg_M = 1'b0; RegDst_M = 5'd7;
            @(posedge Clk);
            #1;
            expQ.push_back(lastExp);
        end
        Stall = 1'b1; Flush = 1'b1;
        @(posedge Clk);
        #1;
        checkIdle("flush", 4'd9);
        Stall = 1'b0; Flush = 1'b0;

        step(1, 32'h4000, 6'h00, 32'h0, D, 32'hCAFE0001, 0, 5'd3, 32'hCAFE0001, 1, 0);
        @(negedge Clk);
        #1;
        Reset = 1'b0;
        #1;
        checkIdle("async_reset", 4'd0);
        check("async_reset_pc_W", pc_W, 32'h0);
        check("async_reset_WbData_W", WbData_W, 32'h0);
        #2;
        Reset = 1'b1;
        expCnt = 4'd0;

        for (int i = 0; i < 17; i++) begin
            step(1, 32'h6000 + 32'(i * 4), 6'h00, 32'h0, D, 32'(i), 0, 5'd5, 32'(i), 1, 0);
        end
        Valid_M = 1'b0;
        @(negedge Clk);
        check("wrap_RetireCnt", 32'(RetireCnt), 32'h1);
        @(negedge Clk);
        check("queue_drained", 32'(expQ.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
MEM/WB pipeline register that sits directly downstream of the data memory in the 5-stage MIPS pipeline. It captures the raw word read by the memory, selects and extends the addressed byte or halfword for lb/lbu/lh/lhu/lw, and presents registered writeback data, destination and enable to the register file and forwarding unit. It also flags misaligned loads and counts retired instructions.

Parameters:
RETIRE_W, 32, width of retired-instruction counter
EN_TRACE, 0, 1 = issue one $display per register-file write

Ports:
Clk  input  1  clock, all state updates on posedge
Reset  input  1  asynchronous, active-low reset
Stall  input  1  hold all W registers this cycle
Flush  input  1  insert bubble into W this cycle
Valid_M  input  1  MEM-stage instruction is valid
pc_M  input  32  MEM-stage PC
IR_M  input  32  MEM-stage instruction
MemAddr_M  input  32  effective address presented to data memory
DataOut_M  input  32  word read from data memory at MemAddr_M[31:2]
AluOut_M  input  32  ALU result for non-load writeback
MemToReg_M  input  1  1 = writeback from memory, 0 = from AluOut_M
RegWrEn_M  input  1  instruction writes register file
RegDst_M  input  5  destination register number
Valid_W  output  1  W-stage instruction valid
pc_W  output  32  W-stage PC
IR_W  output  32  W-stage instruction
WbData_W  output  32  extended writeback data
RegDst_W  output  5  writeback register
RegWrEn_W  output  1  qualified register-file write enable
LoadMisalign_W  output  1  W-stage instruction is a misaligned load
RetireCnt  output  RETIRE_W  retired-instruction count

Behaviour:
- Reset low (async): all outputs 0, including RetireCnt; held until Reset high, capture resumes on first posedge after release.
- Load decode on IR_M[31:26]: lb 6'h20, lh 6'h21, lw 6'h23, lbu 6'h24, lhu 6'h25. Other opcodes with MemToReg_M=1 are treated as lw.
- Extraction is little-endian on MemAddr_M[1:0]: byte k = DataOut_M[8k+7:8k]; halfword at [1]=0 is [15:0], at [1]=1 is [31:16].
- lb/lh sign-extend to 32; lbu/lhu zero-extend; lw passes word unchanged.
- MemToReg_M=0: WbData source is AluOut_M, no extraction.
- Misalign: lh/lhu with addr[0]=1, or lw with addr[1:0]!=0 -> LoadMisalign_W=1, RegWrEn_W=0; WbData_W still loads the extracted value for debug.
- RegWrEn_W = Valid_M & RegWrEn_M & (RegDst_M != 0) & ~misalign, evaluated at capture.
- Latency: exactly one cycle, M inputs at edge n appear on W outputs after edge n.
- Priority per posedge: Flush > Stall > capture.
  - Flush=1: Valid_W, RegWrEn_W, LoadMisalign_W <- 0; other W fields don't-care (implementation clears them to 0); RetireCnt unchanged.
  - Stall=1, Flush=0: every W register holds; RetireCnt holds.
  - Otherwise: all W registers load from M inputs. Valid_M=0 loads a bubble, with RegWrEn_W=0 and LoadMisalign_W=0.
- RetireCnt increments by 1 on each capture edge where Valid_M=1 and no misalign. It wraps modulo 2^RETIRE_W without a flag.
- EN_TRACE=1: on each posedge where the just-loaded RegWrEn_W=1, print "%d@%h: $%d <= %h" with time, pc_W, RegDst_W, WbData_W. Nothing prints for stalled cycles or bubbles.
- Purely registered outputs; no combinational path from any input to any output.

Test Plan:
- Sign/zero extension. DataOut_M=32'h8899AABB, MemToReg=1, RegDst=8, Valid=1:
  - lb addr 0x100 -> WbData_W=FFFFFFBB
  - lbu addr 0x102 -> 00000099
  - lh addr 0x102 -> FFFF8899
  - lhu addr 0x100 -> 0000AABB
  - lw addr 0x100 -> 8899AABB
  - each RegWrEn_W=1 one cycle later
- ALU path. MemToReg=0, AluOut_M=0x12345678, RegDst=0 -> WbData_W=12345678, RegWrEn_W=0 (dst $0). RetireCnt still increments.
- Misalign. lw addr 0x101 -> LoadMisalign_W=1, RegWrEn_W=0, RetireCnt unchanged. lhu addr 0x103 -> same result.
- Stall/flush:
  - Capture lw (pc 0x3000), then Stall=1 for 3 cycles with changing M inputs -> W outputs frozen at pc_W=0x3000.
  - Flush=1 with Stall=1 -> Valid_W=0, RegWrEn_W=0 after the edge.
- Counter wrap. RETIRE_W=4, retire 17 valid non-misaligned instructions -> RetireCnt=1.
- Async reset mid-stream. Drive Reset low between edges while Valid_W=1 -> all outputs 0 immediately, without waiting for Clk. Release; the next capture behaves normally with RetireCnt counting from 0.
